rf_wb: RTL and testbench

Writeback unit that is the single producer of the register file's synchronous write port. It merges single-cycle ALU results with multi-cycle load results through a 2-deep load buffer and drives one write per cycle onto the RF's `rd` address/data pair. It also keeps a 32-bit pending-write scoreboard that the hazard logic queries through two read-style lookup ports.

---
 rtl/rf_wb_pkg.sv | 24 ++
 rtl/rf_wb_if.sv | 12 +
 rtl/rf_wb_fifo.sv | 68 ++++++
 rtl/rf_wb.sv | 101 ++++++++++
 tb/tb_rf_wb.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_pkg.sv
// Shared constants and payload types for the writeback unit.
package rf_wb_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NREGS    = 32;
    localparam int unsigned LB_DEPTH = 2;

    localparam logic [REG_AW-1:0] X0 = '0;

    // One buffered load result.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // Which source owns the RF write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LOAD = 2'd2
    } wb_src_e;

endpackage

// File: rtl/rf_wb_if.sv
// Load-result handshake channel into the writeback unit.
interface rf_wb_if;
    import rf_wb_pkg::*;

    logic              ld_valid;
    logic              ld_ready;
    logic [REG_AW-1:0] ld_rd;
    logic [XLEN-1:0]   ld_data;

    modport master (output ld_valid, ld_rd, ld_data, input ld_ready);
    modport slave  (input ld_valid, ld_rd, ld_data, output ld_ready);
endinterface

// File: rtl/rf_wb_fifo.sv
// Small {rd, data} FIFO holding load results until the write port is free.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int unsigned DEPTH = LB_DEPTH
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  wb_entry_t i_wdata,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_head  = mem_q[head_q];

    // Pointer, count and storage next-state; push and pop may coincide.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_push) begin
            mem_d[tail_q] = i_wdata;
            tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + PTR_W'(1);
        end
        if (i_pop) begin
            head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + PTR_W'(1);
        end
        if (i_push && !i_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!i_push && i_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state; reset empties the buffer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; only entries below count are ever read.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rf_wb.sv
// Writeback unit: ALU/load arbitration onto the RF write port plus the
// pending-write scoreboard used by hazard detection.
module rf_wb
    import rf_wb_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_issue_valid,
    input  logic [REG_AW-1:0] i_issue_rd,
    input  logic              i_alu_valid,
    input  logic [REG_AW-1:0] i_alu_rd,
    input  logic [XLEN-1:0]   i_alu_data,
    rf_wb_if.slave            ld,
    output logic [REG_AW-1:0] o_rd_waddr,
    output logic [XLEN-1:0]   o_rd_wdata,
    input  logic [REG_AW-1:0] i_rs1_addr,
    input  logic [REG_AW-1:0] i_rs2_addr,
    output logic              o_rs1_busy,
    output logic              o_rs2_busy,
    output logic [NREGS-1:0]  o_busy
);

    wb_src_e          src;
    wb_entry_t        fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic [NREGS-1:0] busy_q, busy_d;

    assign ld.ld_ready = !fifo_full;
    // Loads to x0 complete the handshake but are dropped here.
    assign fifo_push   = ld.ld_valid && !fifo_full && (ld.ld_rd != X0) && !i_rst;
    assign fifo_pop    = (src == SRC_LOAD);
    assign o_busy      = busy_q;

    rf_wb_fifo #(.DEPTH(LB_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (fifo_push),
        .i_pop   (fifo_pop),
        .i_wdata (wb_entry_t'{rd: ld.ld_rd, data: ld.ld_data}),
        .o_head  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Write-port arbitration: ALU first, then the oldest buffered load.
    always_comb begin
        src        = SRC_NONE;
        o_rd_waddr = X0;
        o_rd_wdata = '0;
        if (!i_rst) begin
            if (i_alu_valid && (i_alu_rd != X0)) begin
                src        = SRC_ALU;
                o_rd_waddr = i_alu_rd;
                o_rd_wdata = i_alu_data;
            end else if (!fifo_empty) begin
                src        = SRC_LOAD;
                o_rd_waddr = fifo_head.rd;
                o_rd_wdata = fifo_head.data;
            end
        end
    end

    // Scoreboard next-state: clear on write, then set on issue so set wins.
    always_comb begin
        busy_d = busy_q;
        if (o_rd_waddr != X0) begin
            busy_d[o_rd_waddr] = 1'b0;
        end
        if (i_issue_valid && (i_issue_rd != X0)) begin
            busy_d[i_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Lookup ports; optionally hide a register that is being written now.
    always_comb begin
        o_rs1_busy = 1'b0;
        o_rs2_busy = 1'b0;
        if ((i_rs1_addr != X0) && !(BYPASS_EN && (o_rd_waddr == i_rs1_addr))) begin
            o_rs1_busy = busy_q[i_rs1_addr];
        end
        if ((i_rs2_addr != X0) && !(BYPASS_EN && (o_rd_waddr == i_rs2_addr))) begin
            o_rs2_busy = busy_q[i_rs2_addr];
        end
    end

endmodule

// File: tb/tb_rf_wb.sv
// Bench for rf_wb: directed scenarios plus a randomized run against a
// queue-based reference model. Two instances cover both bypass settings.
module tb_rf_wb;
    import rf_wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  rs1, rs2;

    logic [4:0]  w1_waddr, w0_waddr;
    logic [31:0] w1_wdata, w0_wdata;
    logic        w1_rs1b, w1_rs2b, w0_rs1b, w0_rs2b;
    logic [31:0] w1_busy, w0_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    wb_entry_t   mq[$];
    logic [31:0] busy_m = '0;

    always #5 clk = ~clk;

    rf_wb_if if1 ();
    rf_wb_if if0 ();
    assign if1.ld_valid = ld_valid;
    assign if1.ld_rd    = ld_rd;
    assign if1.ld_data  = ld_data;
    assign if0.ld_valid = ld_valid;
    assign if0.ld_rd    = ld_rd;
    assign if0.ld_data  = ld_data;

    rf_wb #(.BYPASS_EN(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
        .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data), .ld(if1),
        .o_rd_waddr(w1_waddr), .o_rd_wdata(w1_wdata), .i_rs1_addr(rs1), .i_rs2_addr(rs2),
        .o_rs1_busy(w1_rs1b), .o_rs2_busy(w1_rs2b), .o_busy(w1_busy)
    );

    rf_wb #(.BYPASS_EN(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
        .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data), .ld(if0),
        .o_rd_waddr(w0_waddr), .o_rd_wdata(w0_wdata), .i_rs1_addr(rs1), .i_rs2_addr(rs2),
        .o_rs1_busy(w0_rs1b), .o_rs2_busy(w0_rs2b), .o_busy(w0_busy)
    );

    // Model: which write the port should carry this cycle.
    function automatic void exp_port(output logic [4:0] a, output logic [31:0] d);
        a = 5'd0;
        d = 32'd0;
        if (!rst) begin
            if (alu_valid && alu_rd != 5'd0) begin
                a = alu_rd;
                d = alu_data;
            end else if (mq.size() > 0) begin
                a = mq[0].rd;
                d = mq[0].data;
            end
        end
    endfunction

    function automatic logic exp_lookup(logic [4:0] addr, logic [4:0] wa, bit byp);
        if (addr == 5'd0) return 1'b0;
        if (byp && wa == addr) return 1'b0;
        return busy_m[addr];
    endfunction

    // Model: all observable outputs packed as {waddr, wdata, ready, rs1b, rs2b, busy}.
    function automatic logic [71:0] exp_all(bit byp);
        logic [4:0]  a;
        logic [31:0] d;
        exp_port(a, d);
        return {a, d, (mq.size() < 2), exp_lookup(rs1, a, byp), exp_lookup(rs2, a, byp), busy_m};
    endfunction

    // Advance one clock edge, updating the model with the current inputs.
    task automatic tick();
        logic [4:0]  a;
        logic [31:0] d;
        bit          alu_win, do_pop, do_push;
        exp_port(a, d);
        alu_win = alu_valid && alu_rd != 5'd0;
        do_pop  = !rst && !alu_win && mq.size() > 0;
        do_push = !rst && ld_valid && mq.size() < 2 && ld_rd != 5'd0;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            busy_m = '0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{rd: ld_rd, data: ld_data});
            if (a != 5'd0) busy_m[a] = 1'b0;
            if (issue_valid && issue_rd != 5'd0) busy_m[issue_rd] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; issue_valid = 1'b0; issue_rd = 5'd0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
        rs1 = 5'd0; rs2 = 5'd0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; issue_valid = 1'b1; issue_rd = 5'd5;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1234;
        ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h55;
        tick();
        n_checks++;
        if (w1_waddr !== 5'd0 || w1_busy !== 32'd0 || if1.ld_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_during: waddr=%0d busy=%h ready=%b required 0/0/1", w1_waddr, w1_busy, if1.ld_ready);
        end
        tick();
        idle();
        rs1 = 5'd5;
        #1;
        n_checks++;
        if (w1_busy !== 32'd0 || w1_waddr !== 5'd0 || w1_wdata !== 32'd0 || if1.ld_ready !== 1'b1 || w1_rs1b !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_after: busy=%h waddr=%0d wdata=%h ready=%b rs1b=%b", w1_busy, w1_waddr, w1_wdata, if1.ld_ready, w1_rs1b);
        end
    endtask

    task automatic test_alu_commit();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick();
        idle();
        rs1 = 5'd5;
        #1;
        n_checks++;
        if (w1_busy[5] !== 1'b1 || w1_rs1b !== 1'b1) begin
            n_errors++;
            $display("FAIL alu_issue: busy5=%b rs1b=%b required 1/1", w1_busy[5], w1_rs1b);
        end
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (w1_waddr !== 5'd5 || w1_wdata !== 32'hDEADBEEF) begin
            n_errors++;
            $display("FAIL alu_port: got %0d/%h required 5/deadbeef", w1_waddr, w1_wdata);
        end
        n_checks++;
        if (w1_rs1b !== 1'b0 || w0_rs1b !== 1'b1) begin
            n_errors++;
            $display("FAIL alu_bypass: byp1=%b byp0=%b required 0/1", w1_rs1b, w0_rs1b);
        end
        tick();
        alu_valid = 1'b0;
        #1;
        n_checks++;
        if (w1_busy[5] !== 1'b0 || w0_busy[5] !== 1'b0 || w0_rs1b !== 1'b0) begin
            n_errors++;
            $display("FAIL alu_clear: busy5=%b/%b rs1b0=%b required 0/0/0", w1_busy[5], w0_busy[5], w0_rs1b);
        end
    endtask

    task automatic test_collision();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = $urandom;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h11;
        #1;
        n_checks++;
        if (if1.ld_ready !== 1'b1 || w1_waddr !== 5'd3) begin
            n_errors++;
            $display("FAIL coll_first: ready=%b waddr=%0d required 1/3", if1.ld_ready, w1_waddr);
        end
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (w1_waddr !== 5'd3) begin
                n_errors++;
                $display("FAIL coll_hold%0d: waddr=%0d required 3", i, w1_waddr);
            end
            tick();
        end
        alu_valid = 1'b0;
        #1;
        n_checks++;
        if (w1_waddr !== 5'd7 || w1_wdata !== 32'h11) begin
            n_errors++;
            $display("FAIL coll_load: got %0d/%h required 7/11", w1_waddr, w1_wdata);
        end
        tick();
        n_checks++;
        if (w1_waddr !== 5'd0) begin
            n_errors++;
            $display("FAIL coll_drain: waddr=%0d required 0", w1_waddr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] dat [3];
        logic [4:0]  rds [3];
        rds[0] = 5'd8; rds[1] = 5'd9; rds[2] = 5'd10;
        for (int k = 0; k < 3; k++) dat[k] = $urandom;
        idle();
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = $urandom;
        ld_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ld_rd = rds[k]; ld_data = dat[k];
            #1;
            n_checks++;
            if (if1.ld_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL bp_accept%0d: ready=%b required 1", k, if1.ld_ready);
            end
            tick();
        end
        ld_rd = rds[2]; ld_data = dat[2];
        #1;
        n_checks++;
        if (if1.ld_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_full: ready=%b required 0", if1.ld_ready);
        end
        tick();
        alu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (w1_waddr !== rds[k] || w1_wdata !== dat[k]) begin
                n_errors++;
                $display("FAIL bp_order%0d: got %0d/%h required %0d/%h", k, w1_waddr, w1_wdata, rds[k], dat[k]);
            end
            tick();
            if (k == 1) ld_valid = 1'b0;
        end
        #1;
        n_checks++;
        if (w1_waddr !== 5'd0 || if1.ld_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_empty: waddr=%0d ready=%b required 0/1", w1_waddr, if1.ld_ready);
        end
    endtask

    task automatic test_x0();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd0;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h77;
        #1;
        n_checks++;
        if (w1_waddr !== 5'd0 || if1.ld_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL x0_port: waddr=%0d ready=%b required 0/1", w1_waddr, if1.ld_ready);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (w1_busy[0] !== 1'b0 || w1_waddr !== 5'd0 || if1.ld_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL x0_after: busy0=%b waddr=%0d ready=%b required 0/0/1", w1_busy[0], w1_waddr, if1.ld_ready);
        end
    endtask

    task automatic test_race();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hA5A5;
        #1;
        n_checks++;
        if (w1_waddr !== 5'd9) begin
            n_errors++;
            $display("FAIL race_port: waddr=%0d required 9", w1_waddr);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (w1_busy[9] !== 1'b1) begin
            n_errors++;
            $display("FAIL race_set: busy9=%b required 1", w1_busy[9]);
        end
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2;
        ld_valid = 1'b1; ld_rd = 5'd11; ld_data = 32'hB;
        tick();
        ld_rd = 5'd12; ld_data = 32'hC;
        tick();
        #1;
        n_checks++;
        if (if1.ld_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL race_full: ready=%b required 0", if1.ld_ready);
        end
        rst = 1'b1;
        tick();
        idle();
        #1;
        n_checks++;
        if (if1.ld_ready !== 1'b1 || w1_busy !== 32'd0 || w1_waddr !== 5'd0) begin
            n_errors++;
            $display("FAIL race_reset: ready=%b busy=%h waddr=%0d required 1/0/0", if1.ld_ready, w1_busy, w1_waddr);
        end
    endtask

    task automatic test_random();
        logic [71:0] e1, e0, g1, g0;
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 63) == 0);
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_rd    = 5'($urandom_range(0, 15));
            alu_valid   = ($urandom_range(0, 9) < 4);
            alu_rd      = 5'($urandom_range(0, 15));
            alu_data    = $urandom;
            ld_valid    = ($urandom_range(0, 9) < 6);
            ld_rd       = 5'($urandom_range(0, 15));
            ld_data     = $urandom;
            rs1         = ($urandom_range(0, 3) == 0) ? alu_rd : 5'($urandom_range(0, 15));
            rs2         = 5'($urandom_range(0, 15));
            #1;
            e1 = exp_all(1'b1);
            e0 = exp_all(1'b0);
            g1 = {w1_waddr, w1_wdata, if1.ld_ready, w1_rs1b, w1_rs2b, w1_busy};
            g0 = {w0_waddr, w0_wdata, if0.ld_ready, w0_rs1b, w0_rs2b, w0_busy};
            n_checks++;
            if (g1 !== e1) begin
                n_errors++;
                $display("FAIL rand_byp1 cycle %0d: got %h required %h", c, g1, e1);
            end
            n_checks++;
            if (g0 !== e0) begin
                n_errors++;
                $display("FAIL rand_byp0 cycle %0d: got %h required %h", c, g0, e0);
            end
            tick();
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_alu_commit();
        test_collision();
        test_back_to_back();
        test_x0();
        test_race();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
